// File: rtl/uart_xfer_pkg.sv
// Shared constants and types for the UART transfer protocol, used by both
// the host-side initiator and the device-side handler.
package uart_xfer_pkg;

  localparam logic [7:0] OPC_W    = 8'd87;
  localparam logic [7:0] OPC_R    = 8'd82;
  localparam logic [7:0] OPC_WB   = 8'd74;
  localparam logic [7:0] OPC_RB   = 8'd77;
  localparam logic [7:0] OPC_ACK  = 8'd55;
  localparam logic [7:0] OPC_NACK = 8'd66;

  typedef enum logic [1:0] {
    OP_W  = 2'd0,
    OP_R  = 2'd1,
    OP_WB = 2'd2,
    OP_RB = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    RESP_ACK     = 2'd0,
    RESP_NACK    = 2'd1,
    RESP_TIMEOUT = 2'd2,
    RESP_BAD     = 2'd3
  } resp_status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_SEND_ADDR,
    ST_SEND_SIZE,
    ST_SEND_DATA,
    ST_WAIT_ACK,
    ST_RECV_DATA,
    ST_DONE
  } xfer_state_e;

  function automatic logic [7:0] op_code(input cmd_op_e op);
    logic [7:0] code;
    case (op)
      OP_W:    code = OPC_W;
      OP_R:    code = OPC_R;
      OP_WB:   code = OPC_WB;
      default: code = OPC_RB;
    endcase
    return code;
  endfunction

  function automatic logic is_read(input cmd_op_e op);
    return (op == OP_R) || (op == OP_RB);
  endfunction

  function automatic logic is_burst(input cmd_op_e op);
    return (op == OP_WB) || (op == OP_RB);
  endfunction

endpackage

// File: rtl/counter.sv
// Small down counter with a fixed load value; last flags the zero count.
module counter #(
  parameter int unsigned      WIDTH      = 2,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '1
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= LOAD_VALUE;
    end else if (dec) begin
      value_reg <= value_reg - WIDTH'(1);
    end
  end

  assign last = (value_reg == '0);

endmodule

// File: rtl/uart_transfer_initiator.sv
// Host-side UART transfer initiator: serializes read/write/burst commands into
// the opcode/address/size/data byte stream and collects ACK/NACK and read data.
module uart_transfer_initiator
  import uart_xfer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_address,
  input  logic [31:0] cmd_size,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        resp_valid,
  output logic [1:0]  resp_status,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  xfer_state_e  state_reg, state_next;
  cmd_op_e      op_reg;
  cmd_op_e      cmd_op_in;
  logic [31:0]  addr_reg;
  logic [31:0]  size_reg;
  logic [31:0]  shift_reg;
  logic [29:0]  word_cnt_reg;
  logic [31:0]  timeout_cnt_reg;
  logic [7:0]   tx_data_reg;
  logic         tx_valid_reg;
  logic         wdata_ready_reg;
  logic [31:0]  rdata_reg;
  logic         rdata_valid_reg;
  logic         resp_valid_reg;
  logic [1:0]   resp_status_reg;
  resp_status_e done_status;

  logic         cnt_load;
  logic         cnt_dec;
  logic         cnt_last;
  logic         tx_fire;
  logic         to_expire;
  logic         last_word;
  logic         burst_empty;
  logic         waiting_rx;
  logic [31:0]  load_word;

  assign cmd_op_in   = cmd_op_e'(cmd_op);
  assign tx_fire     = tx_valid_reg & tx_ready;
  assign to_expire   = (timeout_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign last_word   = (word_cnt_reg == 30'd1);
  assign burst_empty = is_burst(cmd_op_in) && (cmd_size[31:2] == 30'd0);
  assign waiting_rx  = (state_reg == ST_WAIT_ACK) || (state_reg == ST_RECV_DATA);

  // Word whose top byte goes out first when a multi-byte field starts.
  always_comb begin
    load_word = size_reg;
    if (state_reg == ST_SEND_ADDR) begin
      load_word = addr_reg;
    end else if (state_reg == ST_SEND_DATA) begin
      load_word = wdata;
    end
  end

  counter #(
    .WIDTH      (2),
    .LOAD_VALUE (2'd3)
  ) u_byte_idx (
    .clk  (clk),
    .rstn (rstn),
    .load (cnt_load),
    .dec  (cnt_dec),
    .last (cnt_last)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    done_status = RESP_ACK;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (burst_empty) begin
            state_next  = ST_DONE;
            done_status = RESP_BAD;
          end else begin
            state_next = ST_SEND_OP;
          end
        end
      end
      ST_SEND_OP: begin
        if (tx_fire) begin
          state_next = ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR, ST_SEND_SIZE, ST_SEND_DATA: begin
        if (!tx_valid_reg) begin
          cnt_load = (state_reg != ST_SEND_DATA) || wdata_valid;
        end else if (tx_fire) begin
          if (!cnt_last) begin
            cnt_dec = 1'b1;
          end else if (state_reg == ST_SEND_ADDR) begin
            if (is_burst(op_reg)) begin
              state_next = ST_SEND_SIZE;
            end else if (is_read(op_reg)) begin
              state_next = ST_WAIT_ACK;
            end else begin
              state_next = ST_SEND_DATA;
            end
          end else if (state_reg == ST_SEND_SIZE) begin
            state_next = is_read(op_reg) ? ST_WAIT_ACK : ST_SEND_DATA;
          end else if (last_word) begin
            state_next = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_data == OPC_ACK) begin
            if (is_read(op_reg)) begin
              state_next = ST_RECV_DATA;
              cnt_load   = 1'b1;
            end else begin
              state_next = ST_DONE;
            end
          end else if (rx_data == OPC_NACK) begin
            state_next  = ST_DONE;
            done_status = RESP_NACK;
          end else begin
            state_next  = ST_DONE;
            done_status = RESP_BAD;
          end
        end else if (to_expire) begin
          state_next  = ST_DONE;
          done_status = RESP_TIMEOUT;
        end
      end
      ST_RECV_DATA: begin
        if (rx_valid) begin
          if (!cnt_last) begin
            cnt_dec = 1'b1;
          end else if (last_word) begin
            state_next = ST_DONE;
          end else begin
            cnt_load = 1'b1;
          end
        end else if (to_expire) begin
          state_next  = ST_DONE;
          done_status = RESP_TIMEOUT;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg       <= ST_IDLE;
      op_reg          <= OP_W;
      addr_reg        <= '0;
      size_reg        <= '0;
      shift_reg       <= '0;
      word_cnt_reg    <= '0;
      timeout_cnt_reg <= '0;
      tx_data_reg     <= '0;
      tx_valid_reg    <= 1'b0;
      wdata_ready_reg <= 1'b0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      resp_valid_reg  <= 1'b0;
      resp_status_reg <= '0;
    end else begin
      state_reg       <= state_next;
      wdata_ready_reg <= 1'b0;
      rdata_valid_reg <= 1'b0;
      // DONE is entered from exactly one cycle and always left the next.
      resp_valid_reg  <= (state_next == ST_DONE);
      if (state_next == ST_DONE) begin
        resp_status_reg <= done_status;
      end
      // The arriving byte wins over a coincident expiry.
      if (waiting_rx && !rx_valid) begin
        timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
      end else begin
        timeout_cnt_reg <= '0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg       <= cmd_op_in;
            addr_reg     <= cmd_address;
            size_reg     <= cmd_size;
            word_cnt_reg <= is_burst(cmd_op_in) ? cmd_size[31:2] : 30'd1;
          end
        end
        ST_SEND_OP: begin
          if (!tx_valid_reg) begin
            tx_data_reg  <= op_code(op_reg);
            tx_valid_reg <= 1'b1;
          end else if (tx_fire) begin
            tx_valid_reg <= 1'b0;
          end
        end
        ST_SEND_ADDR, ST_SEND_SIZE, ST_SEND_DATA: begin
          if (!tx_valid_reg) begin
            if (cnt_load) begin
              tx_data_reg     <= load_word[31:24];
              shift_reg       <= {load_word[23:0], 8'h00};
              tx_valid_reg    <= 1'b1;
              wdata_ready_reg <= (state_reg == ST_SEND_DATA);
            end
          end else if (tx_fire) begin
            if (cnt_last) begin
              tx_valid_reg <= 1'b0;
              if (state_reg == ST_SEND_DATA) begin
                word_cnt_reg <= word_cnt_reg - 30'd1;
              end
            end else begin
              tx_data_reg <= shift_reg[31:24];
              shift_reg   <= {shift_reg[23:0], 8'h00};
            end
          end
        end
        ST_RECV_DATA: begin
          if (rx_valid) begin
            shift_reg <= {shift_reg[23:0], rx_data};
            if (cnt_last) begin
              rdata_reg       <= {shift_reg[23:0], rx_data};
              rdata_valid_reg <= 1'b1;
              word_cnt_reg    <= word_cnt_reg - 30'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign wdata_ready = wdata_ready_reg;
  assign rdata       = rdata_reg;
  assign rdata_valid = rdata_valid_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_status = resp_status_reg;

endmodule

// File: tb/tb_uart_transfer_initiator.sv
// Scoreboard bench for uart_transfer_initiator: expected tx bytes, read words
// and responses are queued with the stimulus and popped as the DUT emits them.
module tb_uart_transfer_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_address;
  logic [31:0] cmd_size;
  logic [31:0] wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        resp_valid;
  logic [1:0]  resp_status;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int checks_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;
  int tx_hs_cnt  = 0;
  int resp_seen  = 0;
  int rd_seen    = 0;
  int wrdy_cnt   = 0;
  int hs_cyc     = 0;
  int resp_cyc   = 0;
  bit rand_ready = 1'b0;
  bit stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  logic [7:0]  tx_exp_q[$];
  logic [31:0] rd_exp_q[$];
  logic [1:0]  resp_exp_q[$];
  logic [31:0] wq[$];

  uart_transfer_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_address (cmd_address),
    .cmd_size    (cmd_size),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .resp_valid  (resp_valid),
    .resp_status (resp_status),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_tx32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) tx_exp_q.push_back(w[i*8 +: 8]);
  endfunction

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Write-data source: present the head word, advance on each wdata_ready.
  always @(negedge clk) begin
    if (rstn && wdata_ready) begin
      wrdy_cnt++;
      if (wq.size() > 0) void'(wq.pop_front());
    end
    wdata_valid = (wq.size() > 0);
    wdata       = (wq.size() > 0) ? wq[0] : 32'h0;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (stall_prev) begin
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_data), 32'(stall_data));
      end
      if (tx_valid && tx_ready) begin
        tx_hs_cnt++;
        hs_cyc = cyc;
        if (tx_exp_q.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        else check($sformatf("tx_byte%0d", tx_hs_cnt), 32'(tx_data), 32'(tx_exp_q.pop_front()));
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (rdata_valid) begin
        rd_seen++;
        if (rd_exp_q.size() == 0) check("rdata_unexpected", rdata, 32'hFFFF_FFFF);
        else check("rdata", rdata, rd_exp_q.pop_front());
      end
      if (resp_valid) begin
        resp_seen++;
        resp_cyc = cyc;
        if (resp_exp_q.size() == 0) check("resp_unexpected", 32'(resp_status), 32'hFFFF_FFFF);
        else check("resp_status", 32'(resp_status), 32'(resp_exp_q.pop_front()));
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] size);
    @(posedge clk);
    #1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_address = addr;
    cmd_size    = size;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_exp_q.size()), 32'd0);
  endtask

  task automatic wait_resp(input string tag, input int budget);
    int start;
    int n;
    start = resp_seen;
    n = 0;
    while (resp_seen == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, 32'(resp_seen - start), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_hs;
    int start_rd;
    int saved;
    int n;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_address = '0; cmd_size = '0;
    rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_status", 32'(resp_status), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rstn = 1'b1;

    // Single write
    wq.push_back(32'hDEADBEEF);
    tx_exp_q.push_back(8'd87); push_tx32(32'h0000_1000); push_tx32(32'hDEADBEEF);
    resp_exp_q.push_back(2'd0);
    start_hs = tx_hs_cnt;
    issue(2'd0, 32'h0000_1000, 32'd0);
    wait_tx_drain("w_tx_drain", 100);
    check("w_tx_count", 32'(tx_hs_cnt - start_hs), 32'd9);
    send_rx(8'd55);
    check("w_resp_latency", 32'(resp_valid), 32'd1);
    wait_resp("w_done", 20);

    // Single read
    tx_exp_q.push_back(8'd82); push_tx32(32'h20);
    rd_exp_q.push_back(32'h12345678);
    resp_exp_q.push_back(2'd0);
    start_rd = rd_seen;
    issue(2'd1, 32'h20, 32'd0);
    wait_tx_drain("r_tx_drain", 100);
    send_rx(8'd55); send_rx(8'h12); send_rx(8'h34); send_rx(8'h56); send_rx(8'h78);
    wait_resp("r_done", 20);
    check("r_rdata_count", 32'(rd_seen - start_rd), 32'd1);

    // Write burst with a stalling transmitter, busy cmd and a stray rx byte
    rand_ready = 1'b1;
    saved = wrdy_cnt;
    wq.push_back(32'hA1B2C3D4); wq.push_back(32'h0BADF00D);
    tx_exp_q.push_back(8'd74); push_tx32(32'h300); push_tx32(32'd8);
    push_tx32(32'hA1B2C3D4); push_tx32(32'h0BADF00D);
    resp_exp_q.push_back(2'd0);
    issue(2'd2, 32'h300, 32'd8);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_address = 32'h999;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    send_rx(8'd55);
    wait_tx_drain("wb_tx_drain", 400);
    rand_ready = 1'b0;
    send_rx(8'd55);
    wait_resp("wb_done", 20);
    check("wb_wdata_ready_pulses", 32'(wrdy_cnt - saved), 32'd2);

    // Read burst answered with NACK, then with a bad byte
    for (int k = 0; k < 2; k++) begin
      tx_exp_q.push_back(8'd77); push_tx32(32'h400); push_tx32(32'd8);
      resp_exp_q.push_back(k == 0 ? 2'd1 : 2'd3);
      start_rd = rd_seen;
      issue(2'd3, 32'h400, 32'd8);
      wait_tx_drain("rb_tx_drain", 100);
      send_rx(k == 0 ? 8'd66 : 8'h41);
      wait_resp(k == 0 ? "rb_nack_done" : "rb_bad_done", 20);
      check("rb_no_rdata", 32'(rd_seen - start_rd), 32'd0);
    end

    // Read with no reply: 16 idle cycles in WAIT_ACK. The handshake is seen one
    // sample before the edge entering WAIT_ACK, so the sample distance is 17.
    tx_exp_q.push_back(8'd82); push_tx32(32'h40);
    resp_exp_q.push_back(2'd2);
    issue(2'd1, 32'h40, 32'd0);
    wait_tx_drain("to_tx_drain", 100);
    wait_resp("to_done", 100);
    check("to_latency", 32'(resp_cyc - hs_cyc), 32'd17);

    // Reset in the middle of the address field
    tx_exp_q.push_back(8'd82); push_tx32(32'h50);
    start_hs = tx_hs_cnt;
    issue(2'd1, 32'h50, 32'd0);
    n = 0;
    while (tx_hs_cnt < start_hs + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reached_addr", 32'(tx_hs_cnt - start_hs >= 2), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    saved = resp_seen;
    @(posedge clk);
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tx_exp_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_resp", 32'(resp_seen - saved), 32'd0);

    // Burst shorter than one word
    resp_exp_q.push_back(2'd3);
    start_hs = tx_hs_cnt;
    issue(2'd2, 32'h600, 32'd3);
    check("wb3_resp_latency", 32'(resp_valid), 32'd1);
    check("wb3_resp_status", 32'(resp_status), 32'd3);
    wait_resp("wb3_done", 10);
    repeat (5) @(posedge clk);
    #1;
    check("wb3_no_tx", 32'(tx_hs_cnt - start_hs), 32'd0);

    check("end_tx_queue", 32'(tx_exp_q.size()), 32'd0);
    check("end_rd_queue", 32'(rd_exp_q.size()), 32'd0);
    check("end_resp_queue", 32'(resp_exp_q.size()), 32'd0);
    check("end_wdata_queue", 32'(wq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
